// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the accumulator-machine sequencer: opcodes, FSM states,
// control-word bit positions and ALU select codes.
package proc_ctrl_pkg;

    localparam int OP_NOP  = 0;
    localparam int OP_LDAC = 1;
    localparam int OP_STAC = 2;
    localparam int OP_ADD  = 3;
    localparam int OP_SUB  = 4;
    localparam int OP_JMP  = 5;
    localparam int OP_JMPZ = 6;
    localparam int OP_HALT = 15;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_F1     = 4'd1,
        ST_F2     = 4'd2,
        ST_DEC    = 4'd3,
        ST_MRD    = 4'd4,
        ST_EX     = 4'd5,
        ST_MWR    = 4'd6,
        ST_JMP    = 4'd7,
        ST_HALTED = 4'd8,
        ST_FAULT  = 4'd9
    } state_e;

    localparam int CS_W       = 11;
    localparam int CS_PC_INC  = 10;
    localparam int CS_PC_LOAD = 9;
    localparam int CS_IR_LOAD = 8;
    localparam int CS_AR_LOAD = 7;
    localparam int CS_AR_SEL  = 6;
    localparam int CS_MEM_RD  = 5;
    localparam int CS_MEM_WR  = 4;
    localparam int CS_DR_LOAD = 3;
    localparam int CS_AC_LOAD = 2;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; timeout flags the last permitted
// wait cycle (count == WAIT_MAX-1).
module mem_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int CW = $clog2(WAIT_MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout = (cnt_q == CW'(WAIT_MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && !timeout)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/proc_sequencer.sv
// Opcode-driven fetch/decode/execute controller for the accumulator datapath,
// with a ready handshake and timeout on every memory wait state.
module proc_sequencer
    import proc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int OP_W     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero_flag,
    input  logic            mem_ready,
    output logic [CS_W-1:0] ctrlsig,
    output logic            halted,
    output logic            fault,
    output logic            illegal
);
    state_e     state_q, state_d;
    logic [1:0] alu_q, alu_d;
    logic       in_wait, timeout;

    assign in_wait = (state_q == ST_F2) || (state_q == ST_MRD) || (state_q == ST_MWR);

    // Held clear outside wait states, so every entry starts from zero.
    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_wait),
        .en      (in_wait && !mem_ready),
        .timeout (timeout)
    );

    always_comb begin
        state_d = state_q;
        alu_d   = alu_q;
        ctrlsig = '0;
        illegal = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_F1;
            ST_F1: begin
                ctrlsig[CS_AR_LOAD] = 1'b1;
                state_d = ST_F2;
            end
            ST_F2: begin
                ctrlsig[CS_MEM_RD] = 1'b1;
                if (mem_ready) begin
                    ctrlsig[CS_IR_LOAD] = 1'b1;
                    ctrlsig[CS_PC_INC]  = 1'b1;
                    state_d = ST_DEC;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DEC: begin
                case (opcode)
                    OP_W'(OP_NOP):  state_d = ST_F1;
                    OP_W'(OP_LDAC), OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                        ctrlsig[CS_AR_LOAD] = 1'b1;
                        ctrlsig[CS_AR_SEL]  = 1'b1;
                        alu_d   = (opcode == OP_W'(OP_ADD)) ? ALU_ADD :
                                  (opcode == OP_W'(OP_SUB)) ? ALU_SUB : ALU_PASS;
                        state_d = ST_MRD;
                    end
                    OP_W'(OP_STAC): begin
                        ctrlsig[CS_AR_LOAD] = 1'b1;
                        ctrlsig[CS_AR_SEL]  = 1'b1;
                        state_d = ST_MWR;
                    end
                    OP_W'(OP_JMP):  state_d = ST_JMP;
                    OP_W'(OP_JMPZ): state_d = zero_flag ? ST_JMP : ST_F1;
                    OP_W'(OP_HALT): state_d = ST_HALTED;
                    default: begin
                        illegal = 1'b1;
                        state_d = ST_F1;
                    end
                endcase
            end
            ST_MRD: begin
                ctrlsig[CS_MEM_RD] = 1'b1;
                if (mem_ready) begin
                    ctrlsig[CS_DR_LOAD] = 1'b1;
                    state_d = ST_EX;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_EX: begin
                ctrlsig[CS_AC_LOAD] = 1'b1;
                ctrlsig[1:0]        = alu_q;
                state_d = ST_F1;
            end
            ST_MWR: begin
                ctrlsig[CS_MEM_WR] = 1'b1;
                if (mem_ready)    state_d = ST_F1;
                else if (timeout) state_d = ST_FAULT;
            end
            ST_JMP: begin
                ctrlsig[CS_PC_LOAD] = 1'b1;
                state_d = ST_F1;
            end
            ST_HALTED: if (start) state_d = ST_F1;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign halted = (state_q == ST_HALTED);
    assign fault  = (state_q == ST_FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            alu_q   <= ALU_PASS;
        end else begin
            state_q <= state_d;
            alu_q   <= alu_d;
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Random instruction streams with random memory wait lengths, checked cycle by
// cycle against per-instruction control-word sequences.
module tb_proc_sequencer;
    localparam int WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        rst, start, zero_flag, mem_ready;
    logic [3:0]  opcode;
    logic [10:0] ctrlsig;
    logic        halted, fault, illegal;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    proc_sequencer #(.WAIT_MAX(WAIT_MAX), .OP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .zero_flag(zero_flag), .mem_ready(mem_ready), .ctrlsig(ctrlsig),
        .halted(halted), .fault(fault), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom % 2);
    endfunction

    // One clock: drive inputs, compare outputs mid-cycle, advance past the edge.
    task automatic step(input logic [10:0] cs, input logic ill, input logic hlt,
                        input logic flt, input logic mr, input logic st);
        mem_ready = mr;
        start     = st;
        @(negedge clk);
        check("ctrlsig", ctrlsig, cs);
        check("illegal", illegal, ill);
        check("halted",  halted,  hlt);
        check("fault",   fault,   flt);
        @(posedge clk);
        #1;
    endtask

    // Expected sequence starts in F1; opcode is only meaningful in DEC.
    task automatic run_instr(input logic [3:0] op, input logic zf, input int wf, input int wm);
        opcode = 4'($urandom); zero_flag = rb();
        step(11'h080, 0, 0, 0, rb(), rb());
        for (int i = 0; i < wf; i++) step(11'h020, 0, 0, 0, 1'b0, rb());
        step(11'h520, 0, 0, 0, 1'b1, rb());
        opcode = op; zero_flag = zf;
        case (op)
            4'd0: step(11'h000, 0, 0, 0, rb(), 1'b0);
            4'd1, 4'd3, 4'd4: begin
                step(11'h0C0, 0, 0, 0, rb(), rb());
                opcode = 4'($urandom);
                for (int i = 0; i < wm; i++) step(11'h020, 0, 0, 0, 1'b0, rb());
                step(11'h028, 0, 0, 0, 1'b1, rb());
                step(op == 4'd1 ? 11'h004 : op == 4'd3 ? 11'h005 : 11'h006, 0, 0, 0, rb(), rb());
            end
            4'd2: begin
                step(11'h0C0, 0, 0, 0, rb(), rb());
                opcode = 4'($urandom);
                for (int i = 0; i < wm; i++) step(11'h010, 0, 0, 0, 1'b0, rb());
                step(11'h010, 0, 0, 0, 1'b1, rb());
            end
            4'd5: begin
                step(11'h000, 0, 0, 0, rb(), rb());
                step(11'h200, 0, 0, 0, rb(), rb());
            end
            4'd6: begin
                step(11'h000, 0, 0, 0, rb(), rb());
                zero_flag = ~zf;
                if (zf) step(11'h200, 0, 0, 0, rb(), rb());
            end
            4'd15: begin
                step(11'h000, 0, 0, 0, rb(), 1'b0);
                repeat ($urandom_range(0, 2)) step(11'h000, 0, 1, 0, rb(), 1'b0);
                step(11'h000, 0, 1, 0, rb(), 1'b1);
            end
            default: step(11'h000, 1, 0, 0, rb(), rb());
        endcase
    endtask

    task automatic leave_idle();
        step(11'h000, 0, 0, 0, rb(), 1'b0);
        step(11'h000, 0, 0, 0, rb(), 1'b1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1; start = 1'b1; mem_ready = 1'b1;
        #2;
        check("rst_ctrlsig", ctrlsig, 11'h000);
        check("rst_fault",   fault,   1'b0);
        check("rst_halted",  halted,  1'b0);
        check("rst_illegal", illegal, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; zero_flag = 1'b0; mem_ready = 1'b0; opcode = 4'd0;
        @(posedge clk); #1;
        pulse_reset();
        leave_idle();

        // Directed instructions
        run_instr(4'd0, 0, 0, 0);
        run_instr(4'd3, 0, 0, 0);
        run_instr(4'd6, 0, 0, 0);
        run_instr(4'd6, 1, 0, 0);
        run_instr(4'd2, 0, 0, 3);
        run_instr(4'd9, 0, 0, 0);
        run_instr(4'd15, 0, 0, 0);
        run_instr(4'd1, 0, WAIT_MAX - 1, WAIT_MAX - 1);
        run_instr(4'd4, 1, 1, 2);

        for (int n = 0; n < 300; n++)
            run_instr(4'($urandom), rb(), $urandom_range(0, WAIT_MAX - 1),
                      $urandom_range(0, WAIT_MAX - 1));

        // Reset while waiting in MRD abandons the instruction
        opcode = 4'd3;
        step(11'h080, 0, 0, 0, 1'b0, 1'b0);
        step(11'h520, 0, 0, 0, 1'b1, 1'b0);
        step(11'h0C0, 0, 0, 0, 1'b0, 1'b0);
        step(11'h020, 0, 0, 0, 1'b0, 1'b0);
        pulse_reset();
        leave_idle();
        run_instr(4'd0, 0, 0, 0);

        // Fetch timeout: fault is sticky across start pulses
        step(11'h080, 0, 0, 0, rb(), 1'b0);
        for (int i = 0; i < WAIT_MAX; i++) step(11'h020, 0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(11'h000, 0, 0, 1, rb(), 1'b1);
        pulse_reset();
        leave_idle();
        run_instr(4'd5, 0, 0, 0);

        // Data-write timeout
        step(11'h080, 0, 0, 0, rb(), 1'b0);
        step(11'h520, 0, 0, 0, 1'b1, 1'b0);
        opcode = 4'd2;
        step(11'h0C0, 0, 0, 0, rb(), 1'b0);
        for (int i = 0; i < WAIT_MAX; i++) step(11'h010, 0, 0, 0, 1'b0, 1'b0);
        step(11'h000, 0, 0, 1, rb(), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
